// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage and the decode stage that consumes
// IF/ID: the bubble instruction, the reset vector and the instruction field
// offsets.
package if_stage_pkg;

    // sll $0,$0,0: the canonical MIPS no-op, used for every bubble.
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Immediate field of I-type instructions; decode reads the same offsets.
    localparam int IMM_LSB = 0;
    localparam int IMM_MSB = 15;

    // RESET: the pipeline has just come out of reset and IF/ID is invalid.
    // RUN: normal fetch.
    typedef enum logic {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A squash loads a bubble and takes priority over a
// stall, which holds the register's contents.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              squash_i,
    input  logic [31:0]       ir_i,
    input  logic [ADDR_W-1:0] pc4_i,
    output logic [31:0]       ir_o,
    output logic [ADDR_W-1:0] pc4_o,
    output logic              valid_o
);

    logic [31:0]       ir_q,    ir_d;
    logic [ADDR_W-1:0] pc4_q,   pc4_d;
    logic              valid_q, valid_d;

    // Next-state selection: squash, hold, or capture the fetched word.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; that is what keeps this block from inferring a latch.
        ir_d    = ir_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (squash_i) begin
            ir_d    = NOP_WORD;
            pc4_d   = pc4_i;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            ir_d    = ir_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    // Pipeline register with synchronous reset to an invalid bubble.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            ir_q    <= NOP_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign ir_o    = ir_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, sticky
// misaligned-target flag and the IF/ID pipeline register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter logic [31:0]       NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ifid_ir,
    output logic [15:0]       ifid_imm,
    output logic [ADDR_W-1:0] ifid_pc4,
    output logic              ifid_valid,
    output logic              addr_err
);

    fetch_state_e      state_q, state_d;
    logic              in_run;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic              addr_err_q, addr_err_d;
    logic              squash;

    // State register: reset forces RESET, any other edge enters RUN.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RESET;
        else     state_q <= state_d;
    end

    // Next state: the first edge without reset moves to RUN, which is final.
    always_comb begin
        state_d = ST_RUN;
    end

    // State outputs: IF/ID may only capture a real instruction once in RUN.
    always_comb begin
        in_run = (state_q == ST_RUN);
    end

    assign pc_plus4 = pc_q + ADDR_W'(4);

    // Next PC and error flag: redirect beats stall; a target is forced to
    // word alignment and a misaligned one raises the sticky flag.
    always_comb begin
        pc_d       = pc_q;
        addr_err_d = addr_err_q;
        if (redirect) begin
            pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) addr_err_d = 1'b1;
        end else if (!stall) begin
            pc_d = pc_plus4;
        end
    end

    // PC and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            addr_err_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
        end
    end

    // A redirect squashes the wrong-path fetch even when stalled; the first
    // edge out of reset also leaves IF/ID invalid.
    assign squash = redirect | flush | ~in_run;

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .stall_i  (stall),
        .squash_i (squash),
        .ir_i     (imem_rdata),
        .pc4_i    (pc_plus4),
        .ir_o     (ifid_ir),
        .pc4_o    (ifid_pc4),
        .valid_o  (ifid_valid)
    );

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign ifid_imm  = ifid_ir[IMM_MSB:IMM_LSB];
    assign addr_err  = addr_err_q;

endmodule
